// File: rtl/spi_pkg.sv
// Shared encodings for the SPI-slave RAM controller: frame commands and FSM states.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_MEM  = 2'b01,
        RD_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port synchronous RAM, MEM_DEPTH x 8, with a registered read port.
module spi_ram_mem
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // NOTE: the array has no reset branch so it maps onto a RAM macro; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes 10-bit SPI-slave frames into RAM address/data writes and registered reads.
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] din,
    input  logic               rx_valid,
    output logic [DATA_W-1:0]  dout,
    output logic               tx_valid,
    output logic               busy,
    output logic               ovf
);

    state_e                state;
    state_e                state_next;
    cmd_e                  cmd;
    logic [DATA_W-1:0]     payload;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic                  accept;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_SIZE-1:0]  ram_addr;
    logic [DATA_W-1:0]     ram_rdata;

    assign cmd     = cmd_e'(din[9:8]);
    assign payload = din[7:0];
    assign accept  = rx_valid && (state == IDLE);
    assign busy    = (state == RD_MEM) || (state == RD_RESP);

    // Writes only happen in IDLE and reads only in RD_MEM, so one port is shared.
    assign ram_we   = accept && !rst && (cmd == CMD_WR_DATA);
    assign ram_re   = (state == RD_MEM);
    assign ram_addr = ram_re ? rd_addr : wr_addr;

    spi_ram_mem #(
        .ADDR_SIZE (ADDR_SIZE),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (payload),
        .rdata (ram_rdata)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rx_valid && (cmd == CMD_RD_DATA)) state_next = RD_MEM;
            RD_MEM:  state_next = RD_RESP;
            RD_RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_next;
            tx_valid <= 1'b0;
            if (accept) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
                    CMD_WR_DATA: wr_addr <= wr_addr + ADDR_SIZE'(1);
                    CMD_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
                    default:     ;
                endcase
            end
            if (state == RD_MEM) begin
                rd_addr <= rd_addr + ADDR_SIZE'(1);
            end
            if (state == RD_RESP) begin
                dout     <= ram_rdata;
                tx_valid <= 1'b1;
            end
            if (rx_valid && (state != IDLE)) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl: writes, read latency, wrap, overrun, reset.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       busy;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .busy     (busy),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One-cycle frame; returns at the falling edge right after the accepting rising edge.
    task automatic send(input logic [1:0] cmd, input logic [7:0] payload);
        @(negedge clk);
        din      = {cmd, payload};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // RD_DATA accepted at edge N: tx_valid only in the cycle after N+2.
    task automatic do_read(input string tag, input logic [7:0] expected);
        send(2'b11, 8'h00);
        check({tag, "_n1_txv"}, 16'(tx_valid), 16'd0);
        check({tag, "_n1_busy"}, 16'(busy), 16'd1);
        @(negedge clk);
        check({tag, "_n2_txv"}, 16'(tx_valid), 16'd0);
        check({tag, "_n2_busy"}, 16'(busy), 16'd1);
        @(negedge clk);
        check({tag, "_n3_txv"}, 16'(tx_valid), 16'd1);
        check({tag, "_n3_dout"}, 16'(dout), 16'(expected));
        check({tag, "_n3_busy"}, 16'(busy), 16'd0);
        @(negedge clk);
        check({tag, "_n4_txv"}, 16'(tx_valid), 16'd0);
        check({tag, "_n4_dout"}, 16'(dout), 16'(expected));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        din      = '0;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txv", 16'(tx_valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_ovf", 16'(ovf), 16'd0);
        check("rst_dout", 16'(dout), 16'd0);
        rst = 1'b0;

        // Write test
        send(2'b00, 8'h10);
        send(2'b01, 8'hA5);
        send(2'b01, 8'h5A);
        check("wr_mem10", 16'(u_dut.u_mem.mem[8'h10]), 16'h00A5);
        check("wr_mem11", 16'(u_dut.u_mem.mem[8'h11]), 16'h005A);
        check("wr_addr12", 16'(u_dut.wr_addr), 16'h0012);

        // Read latency test
        send(2'b10, 8'h10);
        do_read("rd_a5", 8'hA5);
        do_read("rd_5a", 8'h5A);
        check("rd_addr12", 16'(u_dut.rd_addr), 16'h0012);

        // Write then read at the same address returns the new byte
        send(2'b01, 8'h3C);
        do_read("same_addr", 8'h3C);

        // Wrap test
        send(2'b00, 8'hFF);
        send(2'b01, 8'h11);
        send(2'b01, 8'h22);
        check("wrap_memff", 16'(u_dut.u_mem.mem[8'hFF]), 16'h0011);
        check("wrap_mem00", 16'(u_dut.u_mem.mem[8'h00]), 16'h0022);
        check("wrap_wr_addr", 16'(u_dut.wr_addr), 16'h0001);
        send(2'b10, 8'hFF);
        do_read("wrap_rd_ff", 8'h11);
        do_read("wrap_rd_00", 8'h22);
        check("wrap_rd_addr", 16'(u_dut.rd_addr), 16'h0001);

        // Back-to-back frames, one per cycle
        send(2'b00, 8'h20);
        @(negedge clk);
        din = 10'h101; rx_valid = 1'b1;
        @(negedge clk);
        din = 10'h102;
        @(negedge clk);
        din = 10'h103;
        @(negedge clk);
        rx_valid = 1'b0;
        check("b2b_mem20", 16'(u_dut.u_mem.mem[8'h20]), 16'h0001);
        check("b2b_mem21", 16'(u_dut.u_mem.mem[8'h21]), 16'h0002);
        check("b2b_mem22", 16'(u_dut.u_mem.mem[8'h22]), 16'h0003);
        check("b2b_wr_addr", 16'(u_dut.wr_addr), 16'h0023);

        // Overrun test: mem[1]=0x99, mem[2]=0x44, wr_addr=2, rd_addr=1
        send(2'b00, 8'h01);
        send(2'b01, 8'h99);
        send(2'b01, 8'h44);
        send(2'b00, 8'h02);
        check("ovf_pre", 16'(ovf), 16'd0);
        send(2'b11, 8'h00);
        din = 10'h177; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("ovf_set", 16'(ovf), 16'd1);
        check("ovf_n2_txv", 16'(tx_valid), 16'd0);
        check("ovf_busy", 16'(busy), 16'd1);
        @(negedge clk);
        check("ovf_txv", 16'(tx_valid), 16'd1);
        check("ovf_dout", 16'(dout), 16'h0099);
        check("ovf_wr_addr", 16'(u_dut.wr_addr), 16'h0002);
        check("ovf_mem02", 16'(u_dut.u_mem.mem[8'h02]), 16'h0044);
        check("ovf_rd_addr", 16'(u_dut.rd_addr), 16'h0002);
        send(2'b00, 8'h30);
        repeat (3) @(negedge clk);
        check("ovf_sticky", 16'(ovf), 16'd1);

        // Reset-mid-read test, with a frame offered while rst is high
        send(2'b11, 8'h00);
        rst = 1'b1; din = 10'h055; rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        check("rmr_txv0", 16'(tx_valid), 16'd0);
        check("rmr_busy", 16'(busy), 16'd0);
        check("rmr_dout", 16'(dout), 16'd0);
        check("rmr_ovf", 16'(ovf), 16'd0);
        check("rmr_wr_addr", 16'(u_dut.wr_addr), 16'd0);
        check("rmr_rd_addr", 16'(u_dut.rd_addr), 16'd0);
        @(negedge clk);
        check("rmr_txv1", 16'(tx_valid), 16'd0);
        @(negedge clk);
        check("rmr_txv2", 16'(tx_valid), 16'd0);

        // Read without RD_ADDR uses rd_addr 0; memory survived reset
        do_read("post_rst_rd0", 8'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
